// File: rtl/eth_link_supervisor.sv
// 10GBASE-R link bring-up/recovery supervisor: synchronizes GT/PCS status and sequences RX datapath resets.
// Define ETH_LINK_SUP_STATS_EN to add the saturating link_drop_count statistic.
module eth_link_supervisor #(
  parameter int LOCK_TIMEOUT_CYCLES = 125000,
  parameter int STABLE_CYCLES       = 12500,
  parameter int RESET_PULSE_CYCLES  = 32,
  parameter int MAX_RETRIES         = 15,
  parameter int TIMER_W             = 24
) (
  input  logic       clk_125mhz_int,
  input  logic       gt_tx_reset,
  input  logic       enable,
  input  logic       gt_powergood,
  input  logic       gt_reset_rx_done,
  input  logic       rx_block_lock,
  input  logic       rx_high_ber,
  output logic       rx_datapath_reset,
  output logic       link_up,
  output logic       link_change,
  output logic       link_fail,
  output logic [2:0] state,
  output logic [3:0] retry_count
`ifdef ETH_LINK_SUP_STATS_EN
  ,
  output logic [15:0] link_drop_count
`endif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_GT   = 3'd1,
    WAIT_LOCK = 3'd2,
    QUALIFY   = 3'd3,
    UP        = 3'd4,
    RESET_RX  = 3'd5,
    FAILED    = 3'd6
  } state_e;

  localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] PULSE_LAST  = TIMER_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [3:0]         RETRY_MAX   = 4'(MAX_RETRIES);

  logic [3:0]         sync1_q, sync2_q;
  logic               powergood_s, rx_done_s, lock_s, high_ber_s;
  logic               good, override, enter_reset;
  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         retry_q, retry_d;
  logic               rx_reset_q, rx_reset_d;
  logic               link_up_q, link_up_d;
  logic               link_change_q, link_change_d;
  logic               link_fail_q, link_fail_d;

  // NOTE: the synchronizer flops are reset as well, so the FSM never acts on power-up values from the rx_clk domain.
  always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
    if (gt_tx_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {gt_powergood, gt_reset_rx_done, rx_block_lock, rx_high_ber};
      sync2_q <= sync1_q;
    end
  end

  assign {powergood_s, rx_done_s, lock_s, high_ber_s} = sync2_q;
  assign good     = lock_s & ~high_ber_s & rx_done_s;
  assign override = ~enable | ~powergood_s;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    timer_d     = (timer_q == '1) ? timer_q : timer_q + TIMER_W'(1);
    retry_d     = retry_q;
    enter_reset = 1'b0;

    if (override) begin
      state_d = IDLE;
      retry_d = '0;
    end else begin
      case (state_q)
        IDLE:      state_d = WAIT_GT;
        WAIT_GT: begin
          if (rx_done_s)               state_d = WAIT_LOCK;
          else if (timer_q == LOCK_LAST) enter_reset = 1'b1;
        end
        WAIT_LOCK: begin
          // A lock seen on the timeout cycle still wins.
          if (good)                      state_d = QUALIFY;
          else if (timer_q == LOCK_LAST) enter_reset = 1'b1;
        end
        QUALIFY: begin
          if (!good) begin
            state_d = WAIT_LOCK;
          end else if (timer_q == STABLE_LAST) begin
            state_d = UP;
            retry_d = '0;
          end
        end
        UP:        if (!good) enter_reset = 1'b1;
        RESET_RX:  if (timer_q == PULSE_LAST) state_d = WAIT_GT;
        FAILED:    state_d = FAILED;
        default:   state_d = IDLE;
      endcase
    end

    if (enter_reset) begin
      if (retry_q == RETRY_MAX) begin
        state_d = FAILED;
      end else begin
        state_d = RESET_RX;
        retry_d = retry_q + 4'd1;
      end
    end

    if (state_d != state_q) timer_d = '0;

    // Outputs are decoded from the next state so they move on the same edge as the state register.
    rx_reset_d    = (state_d == RESET_RX);
    link_up_d     = (state_d == UP);
    link_fail_d   = (state_d == FAILED);
    link_change_d = (link_up_d != link_up_q) && !override;
  end

  always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
    if (gt_tx_reset) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      retry_q       <= '0;
      rx_reset_q    <= 1'b0;
      link_up_q     <= 1'b0;
      link_change_q <= 1'b0;
      link_fail_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      rx_reset_q    <= rx_reset_d;
      link_up_q     <= link_up_d;
      link_change_q <= link_change_d;
      link_fail_q   <= link_fail_d;
    end
  end

  assign state             = state_q;
  assign retry_count       = retry_q;
  assign rx_datapath_reset = rx_reset_q;
  assign link_up           = link_up_q;
  assign link_change       = link_change_q;
  assign link_fail         = link_fail_q;

`ifdef ETH_LINK_SUP_STATS_EN
  logic [15:0] drop_count_q;
  logic        drop_event;

  assign drop_event = (state_q == UP) && (state_d == RESET_RX);

  // Survives enable toggles; only the hard reset clears it.
  always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
    if (gt_tx_reset)                              drop_count_q <= '0;
    else if (drop_event && drop_count_q != '1)    drop_count_q <= drop_count_q + 16'd1;
  end

  assign link_drop_count = drop_count_q;
`endif

endmodule
